// File: rtl/gb_video_pkg.sv
// Shared Game Boy video constants and types for the LCD capture path.
package gb_video_pkg;

   localparam int H_PIX          = 160;
   localparam int V_PIX          = 144;
   localparam int BYTES_PER_LINE = 40;
   localparam int FB_BYTES       = 5760;

   typedef enum logic [1:0] {
      FILL,
      OFF,
      WAIT_SYNC,
      ACTIVE
   } cap_state_t;

   typedef logic [1:0] shade_t;

endpackage

// File: rtl/lcd_pixel_packer.sv
// Packs four 2-bit shades into one byte, first pixel in the top bits.
module lcd_pixel_packer
   import gb_video_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       shift,
   input  shade_t     shade,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   logic [5:0] held;
   logic [1:0] group;

   // The fourth shade completes the byte directly from the input.
   assign byte_valid = shift && (group == 2'd3);
   assign byte_data  = {held, shade};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         held  <= '0;
         group <= '0;
      end else if (shift) begin
         held  <= {held[3:0], shade};
         group <= group + 2'd1;
      end
   end

endmodule

// File: rtl/lcd_capture.sv
// Captures the PPU pixel stream into a double-buffered 2bpp framebuffer,
// clearing both banks whenever the display is (re)enabled.
module lcd_capture #(
   parameter int H_PIX       = gb_video_pkg::H_PIX,
   parameter int V_PIX       = gb_video_pkg::V_PIX,
   parameter int IDLE_RESYNC = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        lcd_on,
   input  logic        lcd_clkena,
   input  logic [1:0]  lcd_data,
   output logic        fb_we,
   output logic [13:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        disp_bank,
   output logic        frame_done,
   output logic        sync_err,
   output logic        busy
);

   import gb_video_pkg::*;

   localparam int FB_LEN = (H_PIX / 4) * V_PIX;
   localparam int XW     = $clog2(H_PIX);
   localparam int YW     = $clog2(V_PIX);
   localparam int IW     = $clog2(IDLE_RESYNC + 1);

   cap_state_t    state, next_state;
   logic [12:0]   fill_idx, byte_idx;
   logic          fill_bank, fill_done;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [IW-1:0] idle;
   logic          idle_hit, at_origin, resync, accept, last_pixel, clear_pack;
   logic          wbank, pix_we;
   logic [13:0]   pix_addr;
   logic [7:0]    pix_data;
   logic          byte_valid;
   logic [7:0]    byte_data;

   assign fill_done  = fill_bank && (fill_idx == 13'(FB_LEN - 1));
   assign idle_hit   = (idle == IW'(IDLE_RESYNC));
   assign at_origin  = (x == '0) && (y == '0);
   // lcd_on=0 pre-empts both a strobe and a resync in the same cycle.
   assign resync     = (state == ACTIVE) && lcd_on && idle_hit && !at_origin;
   assign accept     = (state == ACTIVE) && lcd_on && lcd_clkena && !resync;
   assign last_pixel = (x == XW'(H_PIX - 1)) && (y == YW'(V_PIX - 1));
   assign clear_pack = (state != ACTIVE) || resync;

   always_ff @(posedge clk) begin
      if (reset) state <= FILL;
      else       state <= next_state;
   end

   always_comb begin
      // NOTE: default first so every path assigns next_state and no latch is inferred.
      next_state = state;
      case (state)
         FILL:      if (fill_done) next_state = lcd_on ? WAIT_SYNC : OFF;
         OFF:       if (lcd_on) next_state = ACTIVE;
         WAIT_SYNC: begin
            if (!lcd_on)       next_state = FILL;
            else if (idle_hit) next_state = ACTIVE;
         end
         ACTIVE:    if (!lcd_on) next_state = FILL;
         default:   next_state = FILL;
      endcase
   end

   // Fill counter rests at zero outside FILL, so every entry starts at address 0.
   always_ff @(posedge clk) begin
      if (reset || state != FILL) begin
         fill_idx  <= '0;
         fill_bank <= 1'b0;
      end else if (fill_idx == 13'(FB_LEN - 1)) begin
         fill_idx  <= '0;
         fill_bank <= 1'b1;
      end else begin
         fill_idx  <= fill_idx + 13'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || lcd_clkena) idle <= '0;
      else if (!idle_hit)      idle <= idle + IW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x          <= '0;
         y          <= '0;
         byte_idx   <= '0;
         wbank      <= 1'b0;
         disp_bank  <= 1'b1;
         pix_we     <= 1'b0;
         pix_addr   <= '0;
         pix_data   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         pix_we     <= byte_valid;
         frame_done <= byte_valid && last_pixel;
         sync_err   <= resync;
         if (byte_valid) begin
            pix_addr <= {wbank, byte_idx};
            pix_data <= byte_data;
         end
         if (clear_pack) begin
            x        <= '0;
            y        <= '0;
            byte_idx <= '0;
         end else if (accept) begin
            if (byte_valid) byte_idx <= byte_idx + 13'd1;
            if (x == XW'(H_PIX - 1)) begin
               x <= '0;
               if (y == YW'(V_PIX - 1)) begin
                  y         <= '0;
                  byte_idx  <= '0;
                  wbank     <= ~wbank;
                  disp_bank <= wbank;
               end else begin
                  y <= y + YW'(1);
               end
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

   lcd_pixel_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear_pack),
      .shift      (accept),
      .shade      (lcd_data),
      .byte_valid (byte_valid),
      .byte_data  (byte_data)
   );

   assign fb_we   = !reset && ((state == FILL) || pix_we);
   assign fb_addr = (state == FILL) ? {fill_bank, fill_idx} : pix_addr;
   assign fb_data = (state == FILL) ? 8'h00 : pix_data;
   assign busy    = (state != ACTIVE);

endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture: clear fill, two frames, resync, display-off, reset mid-fill.
module tb_lcd_capture;

   localparam int FB_LEN = 5760;
   localparam int N_PIX  = 160 * 144;

   logic        clk = 1'b0;
   logic        reset, lcd_on, lcd_clkena;
   logic [1:0]  lcd_data;
   logic        fb_we, disp_bank, frame_done, sync_err, busy;
   logic [13:0] fb_addr;
   logic [7:0]  fb_data;

   int vectors     = 0;
   int miscompares = 0;

   // Write observer state, reset per scenario.
   int          wr_count, addr_bad, data_bad, done_cnt, sync_cnt, busy_lo;
   logic [13:0] first_addr, last_addr, exp_next, done_addr;
   logic [7:0]  exp_data;
   logic        done_we;

   always #5 clk = ~clk;

   lcd_capture dut (
      .clk        (clk),
      .reset      (reset),
      .lcd_on     (lcd_on),
      .lcd_clkena (lcd_clkena),
      .lcd_data   (lcd_data),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .disp_bank  (disp_bank),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .busy       (busy)
   );

   task automatic clear_mon(input logic [13:0] start, input logic [7:0] data);
      wr_count = 0; addr_bad = 0; data_bad = 0; done_cnt = 0; sync_cnt = 0; busy_lo = 0;
      first_addr = 'x; last_addr = 'x; done_addr = 'x; done_we = 1'b0;
      exp_next = start; exp_data = data;
   endtask

   // Drive inputs just after a rising edge, observe outputs on the falling edge.
   task automatic cyc(input logic r, input logic on, input logic en, input logic [1:0] d);
      @(posedge clk); #1;
      reset = r; lcd_on = on; lcd_clkena = en; lcd_data = d;
      @(negedge clk);
      if (fb_we === 1'b1) begin
         if (wr_count == 0) first_addr = fb_addr;
         if (fb_addr !== exp_next) addr_bad++;
         if (fb_data !== exp_data) data_bad++;
         last_addr = fb_addr;
         wr_count++;
         exp_next = (exp_next[12:0] == 13'(FB_LEN - 1)) ? 14'h2000 : exp_next + 14'd1;
      end
      if (frame_done === 1'b1) begin done_cnt++; done_addr = fb_addr; done_we = fb_we; end
      if (sync_err === 1'b1) sync_cnt++;
      if (busy !== 1'b1) busy_lo++;
   endtask

   task automatic test_reset;
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 2'd0);
      vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL reset_fb_we got %b want 0", fb_we); end
      vectors++; if (fb_addr !== 14'h0000) begin miscompares++; $display("FAIL reset_fb_addr got %h want 0000", fb_addr); end
      vectors++; if (fb_data !== 8'h00) begin miscompares++; $display("FAIL reset_fb_data got %h want 00", fb_data); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
      vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
      vectors++; if (disp_bank !== 1'b1) begin miscompares++; $display("FAIL reset_disp_bank got %b want 1", disp_bank); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy got %b want 1", busy); end
   endtask

   task automatic test_fill;
      clear_mon(14'h0000, 8'h00);
      repeat (2 * FB_LEN + 5) cyc(1'b0, 1'b0, 1'b0, 2'd0);
      vectors++; if (wr_count != 2 * FB_LEN) begin miscompares++; $display("FAIL fill_count got %0d want %0d", wr_count, 2 * FB_LEN); end
      vectors++; if (addr_bad != 0) begin miscompares++; $display("FAIL fill_addr_seq got %0d bad want 0", addr_bad); end
      vectors++; if (data_bad != 0) begin miscompares++; $display("FAIL fill_data got %0d nonzero want 0", data_bad); end
      vectors++; if (first_addr !== 14'h0000) begin miscompares++; $display("FAIL fill_first got %h want 0000", first_addr); end
      vectors++; if (last_addr !== 14'h367F) begin miscompares++; $display("FAIL fill_last got %h want 367f", last_addr); end
      vectors++; if (busy_lo != 0) begin miscompares++; $display("FAIL fill_busy got %0d low cycles want 0", busy_lo); end
   endtask

   task automatic test_frame(input logic bank, input logic want_disp);
      clear_mon({bank, 13'd0}, 8'h1B);
      cyc(1'b0, 1'b1, 1'b0, 2'd0);
      for (int p = 0; p < N_PIX; p++) cyc(1'b0, 1'b1, 1'b1, 2'(p % 4));
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 2'd0);
      vectors++; if (wr_count != FB_LEN) begin miscompares++; $display("FAIL frame%0d_count got %0d want %0d", bank, wr_count, FB_LEN); end
      vectors++; if (addr_bad != 0 || data_bad != 0) begin miscompares++; $display("FAIL frame%0d_writes got %0d addr %0d data bad want 0", bank, addr_bad, data_bad); end
      vectors++; if (first_addr !== {bank, 13'd0}) begin miscompares++; $display("FAIL frame%0d_first got %h want %h", bank, first_addr, {bank, 13'd0}); end
      vectors++; if (last_addr !== {bank, 13'd5759}) begin miscompares++; $display("FAIL frame%0d_last got %h want %h", bank, last_addr, {bank, 13'd5759}); end
      vectors++; if (done_cnt != 1 || done_we !== 1'b1 || done_addr !== {bank, 13'd5759}) begin miscompares++; $display("FAIL frame%0d_done got cnt %0d we %b addr %h want 1 1 %h", bank, done_cnt, done_we, done_addr, {bank, 13'd5759}); end
      vectors++; if (disp_bank !== want_disp) begin miscompares++; $display("FAIL frame%0d_disp_bank got %b want %b", bank, disp_bank, want_disp); end
      vectors++; if (busy !== 1'b0 || sync_cnt != 0) begin miscompares++; $display("FAIL frame%0d_state got busy %b sync %0d want 0 0", bank, busy, sync_cnt); end
   endtask

   task automatic test_resync;
      clear_mon(14'h0000, 8'h1B);
      for (int p = 0; p < 100; p++) cyc(1'b0, 1'b1, 1'b1, 2'(p % 4));
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 2'd0);
      vectors++; if (wr_count != 25 || addr_bad != 0) begin miscompares++; $display("FAIL resync_pre got %0d writes %0d bad want 25 0", wr_count, addr_bad); end
      repeat (1030) cyc(1'b0, 1'b1, 1'b0, 2'd0);
      vectors++; if (sync_cnt != 1) begin miscompares++; $display("FAIL resync_pulse got %0d want 1", sync_cnt); end
      vectors++; if (disp_bank !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL resync_keep got disp %b busy %b want 1 0", disp_bank, busy); end
      clear_mon(14'h0000, 8'h1B);
      for (int p = 0; p < 4; p++) cyc(1'b0, 1'b1, 1'b1, 2'(p % 4));
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 2'd0);
      vectors++; if (wr_count != 1 || first_addr !== 14'h0000 || data_bad != 0) begin miscompares++; $display("FAIL resync_post got %0d writes addr %h want 1 0000", wr_count, first_addr); end
   endtask

   task automatic test_lcd_off;
      clear_mon(14'h0000, 8'h00);
      repeat (1030) cyc(1'b0, 1'b1, 1'b0, 2'd0);
      vectors++; if (sync_cnt != 1) begin miscompares++; $display("FAIL off_realign got %0d want 1", sync_cnt); end
      clear_mon(14'h0000, 8'h00);
      cyc(1'b0, 1'b1, 1'b1, 2'd0);
      cyc(1'b0, 1'b1, 1'b1, 2'd1);
      cyc(1'b0, 1'b0, 1'b1, 2'd2);
      repeat (8) cyc(1'b0, 1'b0, 1'b0, 2'd0);
      vectors++; if (wr_count != 8 || first_addr !== 14'h0000) begin miscompares++; $display("FAIL off_fill got %0d writes from %h want 8 from 0000", wr_count, first_addr); end
      vectors++; if (addr_bad != 0 || data_bad != 0) begin miscompares++; $display("FAIL off_fill_seq got %0d addr %0d data bad want 0", addr_bad, data_bad); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL off_busy got %b want 1", busy); end
   endtask

   task automatic test_reset_mid_fill;
      logic seen = 1'b0;
      for (int n = 0; n < 4000 && !seen; n++) begin
         cyc(1'b0, 1'b0, 1'b0, 2'd0);
         seen = (fb_we === 1'b1) && (fb_addr === 14'd3000);
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL midfill_reach got no write at 3000 want one"); end
      clear_mon(14'h0000, 8'h00);
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 2'd0);
      vectors++; if (wr_count != 0) begin miscompares++; $display("FAIL midfill_in_reset got %0d writes want 0", wr_count); end
      clear_mon(14'h0000, 8'h00);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 2'd0);
      vectors++; if (first_addr !== 14'h0000) begin miscompares++; $display("FAIL midfill_restart got %h want 0000", first_addr); end
      vectors++; if (wr_count != 4 || addr_bad != 0) begin miscompares++; $display("FAIL midfill_seq got %0d writes %0d bad want 4 0", wr_count, addr_bad); end
   endtask

   initial begin
      reset = 1'b1; lcd_on = 1'b0; lcd_clkena = 1'b0; lcd_data = 2'd0;
      test_reset;
      test_fill;
      test_frame(1'b0, 1'b0);
      test_frame(1'b1, 1'b1);
      test_resync;
      test_lcd_off;
      test_reset_mid_fill;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
